decode_exec_reg: RTL and testbench

Decode-to-execute pipeline register for the five-stage MIPS core. Each cycle it latches the decoded instruction into the E stage and resolves read-after-write hazards on rs/rt, either by bypassing from E/M/W or by stalling. It inserts a bubble on load-use hazards and on control flushes. It is the producer of `E_op`/`E_valB` consumed by `aluB` and of the other E-stage operands.

---
 rtl/decode_exec_reg_pkg.sv | 36 +++
 rtl/decode_exec_reg_fwd_sel.sv | 82 ++++++++
 rtl/decode_exec_reg.sv | 136 +++++++++++++
 tb/tb_decode_exec_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_exec_reg_pkg.sv
// decode_exec_reg_pkg
// Shared core definitions for the decode/execute boundary: opcode constants,
// the bubble encoding, the per-cycle E-register selector and source-usage
// helpers. Every decode/execute file takes these from here instead of
// defining its own copies.
package decode_exec_reg_pkg;

    // Opcode encodings (MIPS primary opcode field)
    localparam logic [5:0] IROP  = 6'h00;
    localparam logic [5:0] IJ    = 6'h02;
    localparam logic [5:0] IADDI = 6'h08;
    localparam logic [5:0] IORI  = 6'h0D;
    localparam logic [5:0] ILW   = 6'h23;
    localparam logic [5:0] ISW   = 6'h2B;

    // A bubble is an R-type with funct 0 and no destination, i.e. a NOP.
    localparam logic [5:0] BUBBLE_OP    = IROP;
    localparam logic [5:0] BUBBLE_FUNCT = 6'h00;

    // What the E register captures on the next edge.
    typedef enum logic {
        E_LOAD   = 1'b0,
        E_BUBBLE = 1'b1
    } eSel_t;

    // rs feeds the ALU or address for everything except a jump.
    function automatic logic usesRs(input logic [5:0] op);
        return op != IJ;
    endfunction

    // rt is a true source only for R-type and store data.
    function automatic logic usesRt(input logic [5:0] op);
        return (op == IROP) || (op == ISW);
    endfunction

endpackage

// File: rtl/decode_exec_reg_fwd_sel.sv
// fwd_sel
// Hazard detection and bypass selection for one source operand.
//   srcIdx/srcUsed/regVal : register index, whether the opcode reads it, and
//                           the register-file read data
//   eOp/eDst/eValE        : instruction in E and its combinational result
//   mOp/mDst/mValE/mValM  : instruction in M, its ALU result and load data
//   wDst/wVal             : writeback destination and value
//   fwdVal                : operand value to latch into E
//   loadUse               : the operand cannot be supplied this cycle; stall
// Build option: DEC_EXEC_FORWARD_EN selects the full E/M/W bypass network;
// without it only W write-through remains and any E/M match stalls.
module fwd_sel
    import decode_exec_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic [RW-1:0]    srcIdx,
    input  logic             srcUsed,
    input  logic [WIDTH-1:0] regVal,
    input  logic [5:0]       eOp,
    input  logic [RW-1:0]    eDst,
    input  logic [WIDTH-1:0] eValE,
    input  logic [5:0]       mOp,
    input  logic [RW-1:0]    mDst,
    input  logic [WIDTH-1:0] mValE,
    input  logic [WIDTH-1:0] mValM,
    input  logic [RW-1:0]    wDst,
    input  logic [WIDTH-1:0] wVal,
    output logic [WIDTH-1:0] fwdVal,
    output logic             loadUse
);

    // A zero destination never writes, so it can never match.
    logic eMatch;
    logic mMatch;
    logic wMatch;

    assign eMatch = (eDst != '0) && (eDst == srcIdx);
    assign mMatch = (mDst != '0) && (mDst == srcIdx);
    assign wMatch = (wDst != '0) && (wDst == srcIdx);

`ifdef DEC_EXEC_FORWARD_EN
    always_comb begin
        fwdVal  = regVal;
        loadUse = 1'b0;
        if (srcIdx == '0) begin
            fwdVal = '0;
        end else if (srcUsed) begin
            // Youngest producer wins. A load in E has no data yet, so it
            // is skipped here and reported as a stall instead.
            if (eMatch && (eOp != ILW)) begin
                fwdVal = eValE;
            end else if (mMatch) begin
                fwdVal = (mOp == ILW) ? mValM : mValE;
            end else if (wMatch) begin
                fwdVal = wVal;
            end
            loadUse = eMatch && (eOp == ILW);
        end
    end
`else
    // E/M data paths are not wired in this build.
    logic unusedFwdInputs;
    assign unusedFwdInputs = &{1'b0, eOp, eValE, mOp, mValE, mValM};

    always_comb begin
        fwdVal  = regVal;
        loadUse = 1'b0;
        if (srcIdx == '0) begin
            fwdVal = '0;
        end else if (srcUsed) begin
            if (wMatch) begin
                fwdVal = wVal;
            end
            // Any in-flight producer ahead of W must drain before D issues.
            loadUse = eMatch || mMatch;
        end
    end
`endif

endmodule

// File: rtl/decode_exec_reg.sv
// decode_exec_reg
// Decode-to-execute pipeline register. Latches the decoded instruction with
// forwarded rs/rt operands, or a bubble on a load-use hazard or a flush.
//   clk, reset          : core clock, asynchronous active-high reset (E -> bubble)
//   D_*                 : decoded instruction, register reads and flush request
//   e_valE, M_*, m_valM : in-flight results used for bypassing
//   W_dst, W_val        : writeback port (register-file write-through)
//   E_*                 : registered E-stage fields
//   D_stall             : combinational; holds F and D this cycle
// Build option: DEC_EXEC_FORWARD_EN enables E and M bypassing.
module decode_exec_reg
    import decode_exec_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       D_op,
    input  logic [5:0]       D_funct,
    input  logic [RW-1:0]    D_rs,
    input  logic [RW-1:0]    D_rt,
    input  logic [RW-1:0]    D_dst,
    input  logic [WIDTH-1:0] D_valA,
    input  logic [WIDTH-1:0] D_valB,
    input  logic [WIDTH-1:0] D_imm,
    input  logic             D_flush,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [5:0]       M_op,
    input  logic [RW-1:0]    M_dst,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [RW-1:0]    W_dst,
    input  logic [WIDTH-1:0] W_val,
    output logic [5:0]       E_op,
    output logic [5:0]       E_funct,
    output logic [RW-1:0]    E_dst,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [WIDTH-1:0] E_imm,
    output logic             D_stall
);

    logic [5:0]       eOp_reg,    eOp_next;
    logic [5:0]       eFunct_reg, eFunct_next;
    logic [RW-1:0]    eDst_reg,   eDst_next;
    logic [WIDTH-1:0] eValA_reg,  eValA_next;
    logic [WIDTH-1:0] eValB_reg,  eValB_next;
    logic [WIDTH-1:0] eImm_reg,   eImm_next;

    // Index 0 is rs, index 1 is rt.
    logic [RW-1:0]    srcIdx  [2];
    logic             srcUsed [2];
    logic [WIDTH-1:0] regVal  [2];
    logic [WIDTH-1:0] fwdVal  [2];
    logic             hazard  [2];

    assign srcIdx[0]  = D_rs;
    assign srcIdx[1]  = D_rt;
    assign srcUsed[0] = usesRs(D_op);
    assign srcUsed[1] = usesRt(D_op);
    assign regVal[0]  = D_valA;
    assign regVal[1]  = D_valB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gSrc
            fwd_sel #(.WIDTH(WIDTH), .RW(RW)) uFwdSel (
                .srcIdx  (srcIdx[gi]),
                .srcUsed (srcUsed[gi]),
                .regVal  (regVal[gi]),
                .eOp     (eOp_reg),
                .eDst    (eDst_reg),
                .eValE   (e_valE),
                .mOp     (M_op),
                .mDst    (M_dst),
                .mValE   (M_valE),
                .mValM   (m_valM),
                .wDst    (W_dst),
                .wVal    (W_val),
                .fwdVal  (fwdVal[gi]),
                .loadUse (hazard[gi])
            );
        end
    endgenerate

    logic  anyHazard;
    eSel_t eSel;

    assign anyHazard = hazard[0] | hazard[1];
    // A flushed instruction is discarded, so there is nothing to hold upstream.
    assign D_stall   = anyHazard & ~D_flush;
    assign eSel      = (D_flush | anyHazard) ? E_BUBBLE : E_LOAD;

    always_comb begin
        eOp_next    = BUBBLE_OP;
        eFunct_next = BUBBLE_FUNCT;
        eDst_next   = '0;
        eValA_next  = '0;
        eValB_next  = '0;
        eImm_next   = '0;
        if (eSel == E_LOAD) begin
            eOp_next    = D_op;
            eFunct_next = D_funct;
            eDst_next   = D_dst;
            eValA_next  = fwdVal[0];
            eValB_next  = fwdVal[1];
            eImm_next   = D_imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eOp_reg    <= BUBBLE_OP;
            eFunct_reg <= BUBBLE_FUNCT;
            eDst_reg   <= '0;
            eValA_reg  <= '0;
            eValB_reg  <= '0;
            eImm_reg   <= '0;
        end else begin
            eOp_reg    <= eOp_next;
            eFunct_reg <= eFunct_next;
            eDst_reg   <= eDst_next;
            eValA_reg  <= eValA_next;
            eValB_reg  <= eValB_next;
            eImm_reg   <= eImm_next;
        end
    end

    assign E_op    = eOp_reg;
    assign E_funct = eFunct_reg;
    assign E_dst   = eDst_reg;
    assign E_valA  = eValA_reg;
    assign E_valB  = eValB_reg;
    assign E_imm   = eImm_reg;

endmodule

// File: tb/tb_decode_exec_reg.sv
// tb_decode_exec_reg
// Directed bench for decode_exec_reg. Expected values are hand-derived; the
// sequence adapts to whether DEC_EXEC_FORWARD_EN is defined.
module tb_decode_exec_reg;
    import decode_exec_reg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  D_op, D_funct;
    logic [4:0]  D_rs, D_rt, D_dst;
    logic [31:0] D_valA, D_valB, D_imm;
    logic        D_flush;
    logic [31:0] e_valE;
    logic [5:0]  M_op;
    logic [4:0]  M_dst;
    logic [31:0] M_valE, m_valM;
    logic [4:0]  W_dst;
    logic [31:0] W_val;
    logic [5:0]  E_op, E_funct;
    logic [4:0]  E_dst;
    logic [31:0] E_valA, E_valB, E_imm;
    logic        D_stall;

    int errors = 0;
    int checks = 0;

    decode_exec_reg #(.WIDTH(32), .RW(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .D_op    (D_op),
        .D_funct (D_funct),
        .D_rs    (D_rs),
        .D_rt    (D_rt),
        .D_dst   (D_dst),
        .D_valA  (D_valA),
        .D_valB  (D_valB),
        .D_imm   (D_imm),
        .D_flush (D_flush),
        .e_valE  (e_valE),
        .M_op    (M_op),
        .M_dst   (M_dst),
        .M_valE  (M_valE),
        .m_valM  (m_valM),
        .W_dst   (W_dst),
        .W_val   (W_val),
        .E_op    (E_op),
        .E_funct (E_funct),
        .E_dst   (E_dst),
        .E_valA  (E_valA),
        .E_valB  (E_valB),
        .E_imm   (E_imm),
        .D_stall (D_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setD(input logic [5:0] op, input logic [5:0] funct,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic [31:0] valA, input logic [31:0] valB,
                        input logic [31:0] imm, input logic flush);
        D_op = op; D_funct = funct; D_rs = rs; D_rt = rt; D_dst = dst;
        D_valA = valA; D_valB = valB; D_imm = imm; D_flush = flush;
    endtask

    task automatic setP(input logic [31:0] eVal, input logic [5:0] mOp, input logic [4:0] mDst,
                        input logic [31:0] mValE, input logic [31:0] mValM,
                        input logic [4:0] wDst, input logic [31:0] wVal);
        e_valE = eVal; M_op = mOp; M_dst = mDst; M_valE = mValE; m_valM = mValM;
        W_dst = wDst; W_val = wVal;
    endtask

    // One clock edge, then a one-line transaction record.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t E_op=%0h E_funct=%0h E_dst=%0d E_valA=%0h E_valB=%0h E_imm=%0h",
                 $time, E_op, E_funct, E_dst, E_valA, E_valB, E_imm);
    endtask

    initial begin
        reset = 1'b1;
        setD(IROP, 6'h0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        setP(32'd0, IROP, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        #2;
        chk("rst_op",    {26'd0, E_op},  32'd0);
        chk("rst_dst",   {27'd0, E_dst}, 32'd0);
        chk("rst_valA",  E_valA,         32'd0);
        chk("rst_stall", {31'd0, D_stall}, 32'd0);

        // Plain load of an ADDI
        @(negedge clk);
        reset = 1'b0;
        setD(IADDI, 6'h0, 5'd1, 5'd0, 5'd8, 32'd5, 32'd99, 32'd30, 1'b0);
        #1 chk("addi_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("addi_op",   {26'd0, E_op},  {26'd0, IADDI});
        chk("addi_dst",  {27'd0, E_dst}, 32'd8);
        chk("addi_valA", E_valA,         32'd5);
        chk("addi_imm",  E_imm,          32'd30);

        // Asynchronous reset between edges
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_op",  {26'd0, E_op},  32'd0);
        chk("async_dst", {27'd0, E_dst}, 32'd0);
        chk("async_imm", E_imm,          32'd0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("reload_op",  {26'd0, E_op},  {26'd0, IADDI});
        chk("reload_dst", {27'd0, E_dst}, 32'd8);

        // E=ADDI dst8 result 35; D=ROP rs8 rt9; W dst9 value 77
        @(negedge clk);
        setD(IROP, 6'h20, 5'd8, 5'd9, 5'd10, 32'd1, 32'd2, 32'd0, 1'b0);
        setP(32'd35, IROP, 5'd0, 32'd0, 32'd0, 5'd9, 32'd77);
        #1;
`ifdef DEC_EXEC_FORWARD_EN
        chk("fwd_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("fwd_op",    {26'd0, E_op},    {26'd0, IROP});
        chk("fwd_funct", {26'd0, E_funct}, 32'h20);
        chk("fwd_dst",   {27'd0, E_dst},   32'd10);
        chk("fwd_valA",  E_valA,           32'd35);
        chk("fwd_valB",  E_valB,           32'd77);
`else
        chk("nofwd_e_stall", {31'd0, D_stall}, 32'd1);
        tick();
        chk("nofwd_e_bub_op",  {26'd0, E_op},  32'd0);
        chk("nofwd_e_bub_dst", {27'd0, E_dst}, 32'd0);
        @(negedge clk);
        setP(32'd0, IADDI, 5'd8, 32'd35, 32'd0, 5'd0, 32'd0);
        #1 chk("nofwd_m_stall", {31'd0, D_stall}, 32'd1);
        tick();
        chk("nofwd_m_bub_op", {26'd0, E_op}, 32'd0);
        @(negedge clk);
        setP(32'd0, IROP, 5'd0, 32'd0, 32'd0, 5'd8, 32'd35);
        #1 chk("nofwd_w_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("nofwd_w_funct", {26'd0, E_funct}, 32'h20);
        chk("nofwd_w_dst",   {27'd0, E_dst},   32'd10);
        chk("nofwd_w_valA",  E_valA,           32'd35);
        chk("nofwd_w_valB",  E_valB,           32'd2);
`endif

        // Load into E, dst 8
        @(negedge clk);
        setD(ILW, 6'h0, 5'd2, 5'd0, 5'd8, 32'd100, 32'd0, 32'd4, 1'b0);
        setP(32'd0, IROP, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        #1 chk("lw_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("lw_op",   {26'd0, E_op},  {26'd0, ILW});
        chk("lw_dst",  {27'd0, E_dst}, 32'd8);
        chk("lw_valA", E_valA,         32'd100);

        // Jump with rs field 8 does not read rs
        @(negedge clk);
        setD(IJ, 6'h0, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40, 1'b0);
        #1 chk("j_stall", {31'd0, D_stall}, 32'd0);
        // Store reading rt=8 behind the load
        setD(ISW, 6'h0, 5'd0, 5'd8, 5'd0, 32'd0, 32'd3, 32'd12, 1'b0);
        #1 chk("lu_stall", {31'd0, D_stall}, 32'd1);
        D_flush = 1'b1;
        #1 chk("lu_flush_stall", {31'd0, D_stall}, 32'd0);
        D_flush = 1'b0;
        tick();
        chk("lu_bub_op",   {26'd0, E_op}, 32'd0);
        chk("lu_bub_valB", E_valB,        32'd0);
        chk("lu_bub_imm",  E_imm,         32'd0);
        @(negedge clk);
        setP(32'd0, ILW, 5'd8, 32'd104, 32'd88, 5'd0, 32'd0);
        #1;
`ifdef DEC_EXEC_FORWARD_EN
        chk("lu_m_stall", {31'd0, D_stall}, 32'd0);
        tick();
`else
        chk("lu_m_stall", {31'd0, D_stall}, 32'd1);
        tick();
        chk("lu_m_bub_op", {26'd0, E_op}, 32'd0);
        @(negedge clk);
        setP(32'd0, IROP, 5'd0, 32'd0, 32'd0, 5'd8, 32'd88);
        #1 chk("lu_w_stall", {31'd0, D_stall}, 32'd0);
        tick();
`endif
        chk("sw_op",   {26'd0, E_op}, {26'd0, ISW});
        chk("sw_valB", E_valB,        32'd88);
        chk("sw_imm",  E_imm,         32'd12);

        // Load dst 9 with rs=0 (reads zero), then a flushed dependant
        @(negedge clk);
        setP(32'd0, IROP, 5'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        setD(ILW, 6'h0, 5'd0, 5'd0, 5'd9, 32'd55, 32'd0, 32'd8, 1'b0);
        #1 chk("lw2_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("lw2_dst",  {27'd0, E_dst}, 32'd9);
        chk("lw2_valA", E_valA,         32'd0);
        @(negedge clk);
        setD(IADDI, 6'h0, 5'd9, 5'd0, 5'd4, 32'd1, 32'd0, 32'd7, 1'b1);
        #1 chk("flush_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("flush_op",  {26'd0, E_op},  32'd0);
        chk("flush_dst", {27'd0, E_dst}, 32'd0);
        chk("flush_imm", E_imm,          32'd0);

        // E and M both produce r5: E is the youngest
        @(negedge clk);
        setD(IADDI, 6'h0, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd3, 1'b0);
        tick();
        chk("pri_setup_dst", {27'd0, E_dst}, 32'd5);
        @(negedge clk);
        setD(IORI, 6'h0, 5'd5, 5'd0, 5'd6, 32'd9, 32'd0, 32'd1, 1'b0);
        setP(32'd11, IADDI, 5'd5, 32'd22, 32'd0, 5'd0, 32'd0);
        #1;
`ifdef DEC_EXEC_FORWARD_EN
        chk("pri_stall", {31'd0, D_stall}, 32'd0);
        tick();
        chk("pri_op",   {26'd0, E_op}, {26'd0, IORI});
        chk("pri_valA", E_valA,        32'd11);
`else
        chk("pri_stall", {31'd0, D_stall}, 32'd1);
        tick();
        chk("pri_bub_op", {26'd0, E_op}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
